// File: rtl/seg7_pkg.sv
// ---------------------------------------------------------------------------
// seg7_pkg
// Shared definitions for reading back a multiplexed 7-segment display bus:
// segment bit positions, the sixteen glyph patterns for hex digits 0..F
// (bit0 = seg1/top .. bit6 = seg7/middle, 1 = lit), and the scan FSM states.
// Ports: none (package).
// ---------------------------------------------------------------------------
package seg7_pkg;

   // Segment bit positions on the shared segment bus.
   localparam int SEG_BIT_A = 0;   // seg1, top
   localparam int SEG_BIT_B = 1;   // seg2
   localparam int SEG_BIT_C = 2;   // seg3
   localparam int SEG_BIT_D = 3;   // seg4
   localparam int SEG_BIT_E = 4;   // seg5
   localparam int SEG_BIT_F = 5;   // seg6
   localparam int SEG_BIT_G = 6;   // seg7, middle
   localparam int SEG_W     = 7;

   // Glyph patterns, seg7..seg1.
   localparam logic [6:0] SEG_0 = 7'h3F;
   localparam logic [6:0] SEG_1 = 7'h06;
   localparam logic [6:0] SEG_2 = 7'h5B;
   localparam logic [6:0] SEG_3 = 7'h4F;
   localparam logic [6:0] SEG_4 = 7'h66;
   localparam logic [6:0] SEG_5 = 7'h6D;
   localparam logic [6:0] SEG_6 = 7'h7D;
   localparam logic [6:0] SEG_7 = 7'h07;
   localparam logic [6:0] SEG_8 = 7'h7F;
   localparam logic [6:0] SEG_9 = 7'h67;
   localparam logic [6:0] SEG_A = 7'h77;
   localparam logic [6:0] SEG_B = 7'h7C;
   localparam logic [6:0] SEG_C = 7'h58;
   localparam logic [6:0] SEG_D = 7'h5E;
   localparam logic [6:0] SEG_E = 7'h79;
   localparam logic [6:0] SEG_F = 7'h71;

   // TRACK: waiting for a stable sample window; HOLD: window accepted,
   // waiting for the bus to change.
   typedef enum logic [0:0] {
      TRACK = 1'b0,
      HOLD  = 1'b1
   } scan_state_e;

endpackage

// File: rtl/seg7_pattern_decode.sv
// ---------------------------------------------------------------------------
// seg7_pattern_decode
// Combinational inverse of the hex->7-segment encoding.
// Ports:
//   seg_i     [6:0] segment pattern, bit0 = top .. bit6 = middle, 1 = lit
//   hit_o           1 when seg_i is one of the sixteen hex glyphs
//   nibble_o  [3:0] decoded hex value (0 when hit_o = 0)
// ---------------------------------------------------------------------------
module seg7_pattern_decode
   import seg7_pkg::*;
(
   input  logic [SEG_W-1:0] seg_i,
   output logic             hit_o,
   output logic [3:0]       nibble_o
);

   // Glyph lookup; anything outside the table is reported as a miss.
   always_comb begin
      hit_o    = 1'b1;
      nibble_o = 4'h0;
      case (seg_i)
         SEG_0:   nibble_o = 4'h0;
         SEG_1:   nibble_o = 4'h1;
         SEG_2:   nibble_o = 4'h2;
         SEG_3:   nibble_o = 4'h3;
         SEG_4:   nibble_o = 4'h4;
         SEG_5:   nibble_o = 4'h5;
         SEG_6:   nibble_o = 4'h6;
         SEG_7:   nibble_o = 4'h7;
         SEG_8:   nibble_o = 4'h8;
         SEG_9:   nibble_o = 4'h9;
         SEG_A:   nibble_o = 4'hA;
         SEG_B:   nibble_o = 4'hB;
         SEG_C:   nibble_o = 4'hC;
         SEG_D:   nibble_o = 4'hD;
         SEG_E:   nibble_o = 4'hE;
         SEG_F:   nibble_o = 4'hF;
         default: begin
            hit_o    = 1'b0;
            nibble_o = 4'h0;
         end
      endcase
   end

endmodule

// File: rtl/seg7_scan_decoder.sv
// ---------------------------------------------------------------------------
// seg7_scan_decoder
// Monitors a multiplexed 7-segment bus and recovers the hex nibble shown on
// each digit. The bus is synchronised, must hold STABLE_CYCLES identical
// samples, and is then accepted exactly once per stable window.
// Ports:
//   clk                      system clock
//   reset_n                  asynchronous active-low reset
//   segments  [6:0]          shared segment lines (1 = lit)
//   digit_sel [DIGITS-1:0]   active-high digit strobes
//   clear                    synchronous clear of valid/err/window tracking
//   hex_out   [4*DIGITS-1:0] nibble i at [4i+3:4i]
//   valid     [DIGITS-1:0]   nibble i holds a decoded digit
//   update                   one-cycle pulse when any nibble is written
//   err                      sticky: unknown glyph or multi-hot strobe seen
// ---------------------------------------------------------------------------
module seg7_scan_decoder
   import seg7_pkg::*;
#(
   parameter int DIGITS        = 4,
   parameter int STABLE_CYCLES = 3
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [SEG_W-1:0]    segments,
   input  logic [DIGITS-1:0]   digit_sel,
   input  logic                clear,
   output logic [4*DIGITS-1:0] hex_out,
   output logic [DIGITS-1:0]   valid,
   output logic                update,
   output logic                err
);

   localparam int               CNT_W   = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
   localparam int               SMP_W   = DIGITS + SEG_W;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

   logic [SMP_W-1:0]    sync1_q;
   logic [SMP_W-1:0]    sync2_q;
   logic [SMP_W-1:0]    prev_q;
   logic [CNT_W-1:0]    cnt_q,    cnt_d;
   scan_state_e         state_q,  state_d;
   logic [4*DIGITS-1:0] hex_q,    hex_d;
   logic [DIGITS-1:0]   valid_q,  valid_d;
   logic                update_q, update_d;
   logic                err_q,    err_d;

   logic                same_s;
   logic [DIGITS-1:0]   sel_s;
   logic [SEG_W-1:0]    seg_s;
   logic                hit_s;
   logic [3:0]          nib_s;
   logic                sel_zero_s;
   logic                sel_onehot_s;
   logic                accept_s;

   // Two-flop synchroniser on the whole bus, plus the previous-sample register
   // used for the stability compare.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q <= {SMP_W{1'b0}};
         sync2_q <= {SMP_W{1'b0}};
         prev_q  <= {SMP_W{1'b0}};
      end else begin
         sync1_q <= {digit_sel, segments};
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
      end
   end

   // When the counter is saturated prev_q holds the value of the whole stable
   // window, so the accepted pattern is taken from prev_q, not sync2_q.
   assign same_s       = (sync2_q == prev_q);
   assign sel_s        = prev_q[SMP_W-1:SEG_W];
   assign seg_s        = prev_q[SEG_W-1:0];
   assign sel_zero_s   = (sel_s == {DIGITS{1'b0}});
   assign sel_onehot_s = !sel_zero_s &&
                         ((sel_s & (sel_s - DIGITS'(1'b1))) == {DIGITS{1'b0}});
   assign accept_s     = (state_q == TRACK) && (cnt_q == CNT_MAX) && !clear;

   seg7_pattern_decode u_decode (
      .seg_i    (seg_s),
      .hit_o    (hit_s),
      .nibble_o (nib_s)
   );

   // Next-state logic: stability counter, scan FSM and per-digit capture.
   always_comb begin
      cnt_d    = cnt_q;
      state_d  = state_q;
      hex_d    = hex_q;
      valid_d  = valid_q;
      update_d = 1'b0;
      err_d    = err_q;
      if (clear) begin
         cnt_d   = {CNT_W{1'b0}};
         state_d = TRACK;
         valid_d = {DIGITS{1'b0}};
         err_d   = 1'b0;
      end else begin
         if (!same_s) begin
            cnt_d = {CNT_W{1'b0}};
         end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1'b1);
         end else begin
            cnt_d = cnt_q;
         end

         // If the bus changes in the acceptance cycle a new window is already
         // starting, so stay in TRACK to accept it too.
         case (state_q)
            TRACK: begin
               if ((cnt_q == CNT_MAX) && same_s) begin
                  state_d = HOLD;
               end else begin
                  state_d = TRACK;
               end
            end
            HOLD: begin
               if (!same_s) begin
                  state_d = TRACK;
               end else begin
                  state_d = HOLD;
               end
            end
            default: state_d = TRACK;
         endcase

         if (accept_s) begin
            if (sel_zero_s) begin
               err_d = err_q;           // blanking interval
            end else if (!sel_onehot_s) begin
               err_d = 1'b1;
            end else begin
               for (int i = 0; i < DIGITS; i++) begin
                  if (sel_s[i]) begin
                     if (hit_s) begin
                        hex_d[4*i +: 4] = nib_s;
                        valid_d[i]      = 1'b1;
                        update_d        = 1'b1;
                     end else begin
                        valid_d[i] = 1'b0;
                        err_d      = 1'b1;
                     end
                  end else begin
                     valid_d[i] = valid_d[i];
                  end
               end
            end
         end else begin
            update_d = 1'b0;
         end
      end
   end

   // State and output registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q    <= {CNT_W{1'b0}};
         state_q  <= TRACK;
         hex_q    <= {(4*DIGITS){1'b0}};
         valid_q  <= {DIGITS{1'b0}};
         update_q <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         state_q  <= state_d;
         hex_q    <= hex_d;
         valid_q  <= valid_d;
         update_q <= update_d;
         err_q    <= err_d;
      end
   end

   assign hex_out = hex_q;
   assign valid   = valid_q;
   assign update  = update_q;
   assign err     = err_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// ---------------------------------------------------------------------------
// tb_seg7_scan_decoder
// Self-checking bench: directed stimulus, a run-length model of the sampled
// bus compared against the DUT every cycle, and literal expectations.
// ---------------------------------------------------------------------------
module tb_seg7_scan_decoder;

   localparam int S = 3;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [6:0]  segments;
   logic [3:0]  digit_sel;
   logic        clear;
   logic [15:0] hex_out;
   logic [3:0]  valid;
   logic        update;
   logic        err;

   seg7_scan_decoder #(.DIGITS(4), .STABLE_CYCLES(S)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .segments  (segments),
      .digit_sel (digit_sel),
      .clear     (clear),
      .hex_out   (hex_out),
      .valid     (valid),
      .update    (update),
      .err       (err)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int upd_seen = 0;

   logic [6:0]  pat [16];
   logic [10:0] pipe [3];
   logic [10:0] last_smp;
   int          run_len;
   logic [15:0] m_hex;
   logic [3:0]  m_valid;
   logic        m_upd;
   logic        m_err;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 3; i++) pipe[i] = 11'h000;
      last_smp = 11'h000;
      run_len  = 0;
      m_hex    = 16'h0000;
      m_valid  = 4'h0;
      m_upd    = 1'b0;
      m_err    = 1'b0;
   endtask

   // Model: the bus sample seen 3 edges ago is judged; a run of S identical
   // samples (restarted by clear) is accepted once.
   task automatic model_edge();
      logic [10:0] j;
      logic [3:0]  sel;
      logic [6:0]  seg;
      int          idx;
      int          found;
      if (!reset_n) begin
         model_reset();
         return;
      end
      j       = pipe[2];
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = {digit_sel, segments};
      m_upd   = 1'b0;
      if (clear) begin
         run_len = 0;
         m_valid = 4'h0;
         m_err   = 1'b0;
      end else begin
         if (run_len == 0 || j != last_smp) run_len = 1;
         else run_len++;
         if (run_len == S) begin
            sel = j[10:7];
            seg = j[6:0];
            if ($countones(sel) > 1) begin
               m_err = 1'b1;
            end else if ($countones(sel) == 1) begin
               idx   = 0;
               found = -1;
               for (int k = 0; k < 4; k++) if (sel[k]) idx = k;
               for (int v = 0; v < 16; v++) if (pat[v] == seg) found = v;
               if (found >= 0) begin
                  m_hex[4*idx +: 4] = 4'(found);
                  m_valid[idx]      = 1'b1;
                  m_upd             = 1'b1;
               end else begin
                  m_valid[idx] = 1'b0;
                  m_err        = 1'b1;
               end
            end
         end
      end
      last_smp = j;
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check("hex_out", {16'h0000, hex_out}, {16'h0000, m_hex});
      check("valid", {28'h0, valid}, {28'h0, m_valid});
      check("update", {31'h0, update}, {31'h0, m_upd});
      check("err", {31'h0, err}, {31'h0, m_err});
      if (update === 1'b1) upd_seen++;
   endtask

   task automatic drive(input logic [3:0] sel, input logic [6:0] seg, input logic clr);
      digit_sel = sel;
      segments  = seg;
      clear     = clr;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1);
   end

   initial begin
      int first;
      pat[0]  = 7'h3F; pat[1]  = 7'h06; pat[2]  = 7'h5B; pat[3]  = 7'h4F;
      pat[4]  = 7'h66; pat[5]  = 7'h6D; pat[6]  = 7'h7D; pat[7]  = 7'h07;
      pat[8]  = 7'h7F; pat[9]  = 7'h67; pat[10] = 7'h77; pat[11] = 7'h7C;
      pat[12] = 7'h58; pat[13] = 7'h5E; pat[14] = 7'h79; pat[15] = 7'h71;

      // Reset with active inputs.
      reset_n = 1'b0;
      drive(4'b0001, 7'h3F, 1'b0);
      model_reset();
      repeat (4) step();
      check("rst_hex", {16'h0, hex_out}, 32'h0);
      check("rst_valid", {28'h0, valid}, 32'h0);
      check("rst_update", {31'h0, update}, 32'h0);
      check("rst_err", {31'h0, err}, 32'h0);
      reset_n  = 1'b1;
      upd_seen = 0;
      repeat (5) step();
      check("rel_no_update", upd_seen, 32'd0);
      check("rel_valid_low", {28'h0, valid}, 32'h0);
      step();
      check("rel_first_update", {31'h0, update}, 32'h1);
      check("rel_valid0", {28'h0, valid}, 32'h1);

      // Full glyph table on digit 0.
      drive(4'b0000, 7'h00, 1'b0);
      repeat (3) step();
      for (int v = 0; v < 16; v++) begin
         drive(4'b0001, pat[v], 1'b0);
         upd_seen = 0;
         first    = -1;
         for (int k = 1; k <= 6; k++) begin
            step();
            if (update === 1'b1 && first < 0) first = k;
         end
         check("table_nibble", {28'h0, hex_out[3:0]}, v);
         check("table_valid0", {31'h0, valid[0]}, 32'h1);
         check("table_latency", first, 32'd6);
         check("table_pulses", upd_seen, 32'd1);
      end

      // Scan sweep: digits 0..3 show 1,2,3,4.
      for (int sw = 0; sw < 2; sw++) begin
         upd_seen = 0;
         for (int d = 0; d < 4; d++) begin
            drive(4'(1 << d), pat[d+1], 1'b0);
            repeat (8) step();
         end
         check("scan_pulses", upd_seen, 32'd4);
      end
      check("scan_hex", {16'h0, hex_out}, 32'h4321);
      check("scan_valid", {28'h0, valid}, 32'hF);

      // Glitching digit 2, then a steady 8.
      upd_seen = 0;
      for (int k = 0; k < 10; k++) begin
         drive(4'b0100, (k % 2 == 1) ? pat[9] : pat[5], 1'b0);
         step();
      end
      check("glitch_no_update", upd_seen, 32'd0);
      check("glitch_valid", {28'h0, valid}, 32'hF);
      drive(4'b0100, 7'h7F, 1'b0);
      repeat (8) step();
      check("glitch_then_8", {16'h0, hex_out}, 32'h4821);

      // Error cases.
      drive(4'b0010, 7'h00, 1'b0);
      repeat (8) step();
      check("unknown_err", {31'h0, err}, 32'h1);
      check("unknown_valid", {28'h0, valid}, 32'hD);
      check("unknown_hex_kept", {16'h0, hex_out}, 32'h4821);
      drive(4'b0000, 7'h00, 1'b1);
      step();
      drive(4'b0000, 7'h00, 1'b0);
      check("clear_err", {31'h0, err}, 32'h0);
      check("clear_valid", {28'h0, valid}, 32'h0);
      check("clear_hex_kept", {16'h0, hex_out}, 32'h4821);
      repeat (5) step();
      drive(4'b0110, 7'h3F, 1'b0);
      repeat (8) step();
      check("multihot_err", {31'h0, err}, 32'h1);
      check("multihot_hex", {16'h0, hex_out}, 32'h4821);
      drive(4'b0000, 7'h12, 1'b0);
      repeat (8) step();
      check("blank_keeps_err", {31'h0, err}, 32'h1);
      drive(4'b0000, 7'h12, 1'b1);
      step();
      drive(4'b0000, 7'h12, 1'b0);
      repeat (8) step();
      check("blank_no_err", {31'h0, err}, 32'h0);

      // Clear on the acceptance cycle.
      drive(4'b0001, pat[5], 1'b0);
      repeat (5) step();
      drive(4'b0001, pat[5], 1'b1);
      step();
      check("race_no_update", {31'h0, update}, 32'h0);
      check("race_valid", {28'h0, valid}, 32'h0);
      drive(4'b0001, pat[5], 1'b0);
      upd_seen = 0;
      repeat (2) step();
      check("race_wait", upd_seen, 32'd0);
      step();
      check("race_reaccept", {31'h0, update}, 32'h1);
      check("race_hex", {16'h0, hex_out}, 32'h4825);

      // Reset in the middle of a window.
      drive(4'b1000, pat[14], 1'b0);
      repeat (2) step();
      reset_n = 1'b0;
      model_reset();
      step();
      check("midrst_hex", {16'h0, hex_out}, 32'h0);
      check("midrst_valid", {28'h0, valid}, 32'h0);
      reset_n  = 1'b1;
      upd_seen = 0;
      repeat (5) step();
      check("midrst_no_update", upd_seen, 32'd0);
      step();
      check("midrst_update", {31'h0, update}, 32'h1);
      check("midrst_nibble3", {28'h0, hex_out[15:12]}, 32'hE);

      // Same value written again still pulses update.
      drive(4'b0000, 7'h00, 1'b0);
      repeat (4) step();
      drive(4'b1000, pat[14], 1'b0);
      upd_seen = 0;
      repeat (6) step();
      check("rewrite_pulse", upd_seen, 32'd1);
      check("rewrite_hex", {16'h0, hex_out}, 32'hE000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
